// File: rtl/i2s_codec_tx.sv
// i2s_codec_tx: serialises parallel left/right sample pairs into an I2S stream
// (bclk, lrck, sdata) for the codec DAC, in the AUDIO_CLK domain.
// Ports:
//   AUDIO_CLK    block clock
//   reset_data   asynchronous active-high reset
//   enable       1 = run the serializer, 0 = return to IDLE
//   lsound_in    left sample, two's complement, MSB first on the wire
//   rsound_in    right sample
//   sample_valid one-cycle strobe, lsound_in/rsound_in valid this cycle
//   err_clr      one-cycle clear of the sticky error flags
//   frame_req    one-cycle pulse at every frame start (drives synth trig)
//   bclk         I2S bit clock
//   lrck         I2S word select, 0 = left, 1 = right
//   sdata        I2S serial data, one bclk delayed from lrck edge, zero padded
//   underrun     sticky: a frame started without a fresh sample pair
//   overrun      sticky: a second sample pair arrived before the first was used
module i2s_codec_tx #(
  parameter int unsigned AUD_BIT_DEPTH = 24,
  parameter int unsigned SLOT_BITS     = 32,
  parameter int unsigned BCLK_DIV      = 8
) (
  input  logic                     AUDIO_CLK,
  input  logic                     reset_data,
  input  logic                     enable,
  input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
  input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
  input  logic                     sample_valid,
  input  logic                     err_clr,
  output logic                     frame_req,
  output logic                     bclk,
  output logic                     lrck,
  output logic                     sdata,
  output logic                     underrun,
  output logic                     overrun
);

  localparam int unsigned DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(2 * SLOT_BITS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                   state;
  logic [DIV_W-1:0]         div_cnt;
  logic [BIT_W-1:0]         bit_cnt;
  logic                     started;
  logic                     fresh;
  logic [AUD_BIT_DEPTH-1:0] lhold;
  logic [AUD_BIT_DEPTH-1:0] rhold;
  logic [AUD_BIT_DEPTH-1:0] lshift;
  logic [AUD_BIT_DEPTH-1:0] rshift;

  logic                     div_wrap;
  logic                     fall_evt;
  logic                     frame_start;
  logic [DIV_W-1:0]         div_cnt_nxt;
  logic [BIT_W-1:0]         bit_cnt_nxt;
  logic                     in_right;
  logic [BIT_W-1:0]         slot_pos;
  logic                     emit_bit;

  // Divider/bit-counter look-ahead; frame start is the first fall after RUN entry or a bit counter wrap.
  always_comb begin
    div_wrap    = (div_cnt == DIV_W'(BCLK_DIV - 1));
    fall_evt    = (state == RUN) && enable && div_wrap;
    frame_start = fall_evt && (!started || (bit_cnt == BIT_W'(2 * SLOT_BITS - 1)));
    div_cnt_nxt = div_wrap ? '0 : DIV_W'(div_cnt + DIV_W'(1));
    bit_cnt_nxt = frame_start ? '0 : BIT_W'(bit_cnt + BIT_W'(1));
    in_right    = (bit_cnt_nxt >= BIT_W'(SLOT_BITS));
    slot_pos    = in_right ? BIT_W'(bit_cnt_nxt - BIT_W'(SLOT_BITS)) : bit_cnt_nxt;
    emit_bit    = (slot_pos != '0) && (slot_pos <= BIT_W'(AUD_BIT_DEPTH));
  end

  // FSM, serializer, sample capture and sticky error flags.
  always_ff @(posedge AUDIO_CLK or posedge reset_data) begin
    if (reset_data) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      started   <= 1'b0;
      fresh     <= 1'b0;
      lhold     <= '0;
      rhold     <= '0;
      lshift    <= '0;
      rshift    <= '0;
      frame_req <= 1'b0;
      bclk      <= 1'b0;
      lrck      <= 1'b0;
      sdata     <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_req <= 1'b0;

      // A capture in the frame-start cycle refills fresh after the shift took the old pair.
      if (sample_valid) begin
        lhold <= lsound_in;
        rhold <= rsound_in;
        fresh <= 1'b1;
      end else if (frame_start) begin
        fresh <= 1'b0;
      end

      if (frame_start && !fresh) begin
        underrun <= 1'b1;
      end else if (err_clr) begin
        underrun <= 1'b0;
      end

      if (sample_valid && fresh && !frame_start) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          started <= 1'b0;
          bclk    <= 1'b0;
          lrck    <= 1'b0;
          sdata   <= 1'b0;
          if (enable) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            started <= 1'b0;
            bclk    <= 1'b0;
            lrck    <= 1'b0;
            sdata   <= 1'b0;
          end else begin
            div_cnt <= div_cnt_nxt;
            bclk    <= (div_cnt_nxt >= DIV_W'(BCLK_DIV / 2));
            if (fall_evt) begin
              started   <= 1'b1;
              bit_cnt   <= bit_cnt_nxt;
              lrck      <= in_right;
              frame_req <= frame_start;
              if (frame_start) begin
                lshift <= lhold;
                rshift <= rhold;
                sdata  <= 1'b0;
              end else if (emit_bit && in_right) begin
                sdata  <= rshift[AUD_BIT_DEPTH-1];
                rshift <= {rshift[AUD_BIT_DEPTH-2:0], 1'b0};
              end else if (emit_bit) begin
                sdata  <= lshift[AUD_BIT_DEPTH-1];
                lshift <= {lshift[AUD_BIT_DEPTH-2:0], 1'b0};
              end else begin
                sdata  <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_codec_tx.sv
// tb_i2s_codec_tx: directed, table-driven bench for i2s_codec_tx with default parameters.
module tb_i2s_codec_tx;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [23:0] lsound;
  logic [23:0] rsound;
  logic        sample_valid;
  logic        err_clr;
  logic        frame_req;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic        underrun;
  logic        overrun;

  int n_checks;
  int n_errors;

  i2s_codec_tx dut (
    .AUDIO_CLK   (clk),
    .reset_data  (rst),
    .enable      (enable),
    .lsound_in   (lsound),
    .rsound_in   (rsound),
    .sample_valid(sample_valid),
    .err_clr     (err_clr),
    .frame_req   (frame_req),
    .bclk        (bclk),
    .lrck        (lrck),
    .sdata       (sdata),
    .underrun    (underrun),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  vec_t vecs [4];

  localparam logic [63:0] LRCK_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_sv(input logic [23:0] l, input logic [23:0] r);
    sample_valid = 1'b1;
    lsound       = l;
    rsound       = r;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Waits for frame_req, then captures one 512-cycle frame sampling mid bclk-high;
  // optionally pulses sample_valid at the start of bit give_bit. Returns at the next frame_req cycle.
  task automatic run_frame(input int give_bit, input logic [23:0] nl, input logic [23:0] nr,
                           output logic [31:0] ls, output logic [31:0] rs,
                           output logic [63:0] lr, output int bad);
    int n;
    ls  = '0;
    rs  = '0;
    lr  = '0;
    bad = 0;
    n   = 0;
    while (frame_req !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (frame_req !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_req_timeout: got no frame_req within %0d cycles, required one", n);
      return;
    end
    for (int b = 0; b < 64; b++) begin
      for (int j = 0; j < 8; j++) begin
        if (b == give_bit && j == 0) begin
          sample_valid = 1'b1;
          lsound       = nl;
          rsound       = nr;
        end else begin
          sample_valid = 1'b0;
        end
        if (j == 0 && bclk !== 1'b0) bad++;
        if (b > 0 && frame_req !== 1'b0) bad++;
        if (j == 4) begin
          if (bclk !== 1'b1) bad++;
          if (b < 32) ls = {ls[30:0], sdata};
          else        rs = {rs[30:0], sdata};
          lr = {lr[62:0], lrck};
        end
        @(negedge clk);
      end
    end
    sample_valid = 1'b0;
  endtask

  logic [31:0] ls, rs;
  logic [63:0] lr;
  int          bad;
  int          n;

  initial begin
    vecs[0] = '{24'hA5F00F, 24'h123456, {1'b0, 24'hA5F00F, 7'd0}, {1'b0, 24'h123456, 7'd0}};
    vecs[1] = '{24'h800000, 24'h7FFFFF, {1'b0, 24'h800000, 7'd0}, {1'b0, 24'h7FFFFF, 7'd0}};
    vecs[2] = '{24'h000001, 24'hFFFFFF, {1'b0, 24'h000001, 7'd0}, {1'b0, 24'hFFFFFF, 7'd0}};
    vecs[3] = '{24'h000000, 24'h5A5A5A, 32'h0000_0000,            {1'b0, 24'h5A5A5A, 7'd0}};

    n_checks     = 0;
    n_errors     = 0;
    clk          = 1'b0;
    rst          = 1'b1;
    enable       = 1'b0;
    lsound       = '0;
    rsound       = '0;
    sample_valid = 1'b0;
    err_clr      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_frame_req", frame_req, 0);
    check("rst_bclk",      bclk,      0);
    check("rst_lrck",      lrck,      0);
    check("rst_sdata",     sdata,     0);
    check("rst_underrun",  underrun,  0);
    check("rst_overrun",   overrun,   0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames: each frame loads the next vector mid-frame
    pulse_sv(vecs[0].l, vecs[0].r);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_frame((i < 3) ? 8 : -1, vecs[(i < 3) ? i + 1 : i].l, vecs[(i < 3) ? i + 1 : i].r,
                ls, rs, lr, bad);
      check($sformatf("l_slot_v%0d", i), ls, vecs[i].exp_l);
      check($sformatf("r_slot_v%0d", i), rs, vecs[i].exp_r);
      check($sformatf("lrck_v%0d", i), lr, LRCK_EXP);
      check($sformatf("bclk_shape_v%0d", i), bad, 0);
      if (i < 3) begin
        check($sformatf("no_underrun_v%0d", i), underrun, 0);
        check($sformatf("no_overrun_v%0d", i), overrun, 0);
      end
    end

    // Underrun: frame 4 starts without fresh data, replays vector 3
    check("underrun_set", underrun, 1);
    run_frame(-1, '0, '0, ls, rs, lr, bad);
    check("replay_l", ls, vecs[3].exp_l);
    check("replay_r", rs, vecs[3].exp_r);
    pulse_clr();
    check("underrun_clr", underrun, 0);
    n = 1;
    while (frame_req !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("frame_period", n, 512);
    pulse_clr();
    check("underrun_clr2", underrun, 0);
    repeat (510) @(negedge clk);
    pulse_clr();
    check("frame_req_at_clr", frame_req, 1);
    check("underrun_set_wins", underrun, 1);

    // Overrun: X then Y inside one frame, Y is emitted
    @(negedge clk);
    pulse_clr();
    check("underrun_clr3", underrun, 0);
    repeat (18) @(negedge clk);
    pulse_sv(24'h0F0F0F, 24'h111111);
    check("overrun_first_ok", overrun, 0);
    repeat (19) @(negedge clk);
    pulse_sv(24'hC3C3C3, 24'hEEEEEE);
    check("overrun_set", overrun, 1);
    pulse_clr();
    check("overrun_clr", overrun, 0);
    run_frame(0, 24'h600006, 24'h00FF00, ls, rs, lr, bad);
    check("last_wins_l", ls, {1'b0, 24'hC3C3C3, 7'd0});
    check("last_wins_r", rs, {1'b0, 24'hEEEEEE, 7'd0});
    check("sv_at_frame_req_no_overrun", overrun, 0);
    check("sv_at_frame_req_no_underrun", underrun, 0);
    run_frame(-1, '0, '0, ls, rs, lr, bad);
    check("sv_at_frame_req_l", ls, {1'b0, 24'h600006, 7'd0});
    check("sv_at_frame_req_r", rs, {1'b0, 24'h00FF00, 7'd0});

    // Disable mid right slot, then re-enable
    repeat (8 * 40 + 5) @(negedge clk);
    check("pre_dis_lrck", lrck, 1);
    check("pre_dis_bclk", bclk, 1);
    enable = 1'b0;
    @(negedge clk);
    check("dis_bclk",      bclk,      0);
    check("dis_lrck",      lrck,      0);
    check("dis_sdata",     sdata,     0);
    check("dis_frame_req", frame_req, 0);
    repeat (5) @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (frame_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reenable_latency", n, 9);
    run_frame(-1, '0, '0, ls, rs, lr, bad);
    check("reenable_l", ls, {1'b0, 24'h600006, 7'd0});
    check("reenable_r", rs, {1'b0, 24'h00FF00, 7'd0});
    check("reenable_lrck", lr, LRCK_EXP);
    check("underrun_sticky", underrun, 1);

    // Asynchronous reset mid-frame
    repeat (10) @(negedge clk);
    pulse_sv(24'h3C3C3C, 24'h999999);
    repeat (9) @(negedge clk);
    pulse_sv(24'h7E7E7E, 24'h818181);
    check("overrun_pre_rst", overrun, 1);
    repeat (304) @(negedge clk);
    check("pre_rst_bclk", bclk, 1);
    check("pre_rst_lrck", lrck, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_bclk",      bclk,      0);
    check("arst_lrck",      lrck,      0);
    check("arst_sdata",     sdata,     0);
    check("arst_frame_req", frame_req, 0);
    check("arst_underrun",  underrun,  0);
    check("arst_overrun",   overrun,   0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(-1, '0, '0, ls, rs, lr, bad);
    check("hold_cleared_l", ls, 0);
    check("hold_cleared_r", rs, 0);
    check("post_rst_underrun", underrun, 1);
    check("post_rst_overrun", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
